alu_exec_ctrl: RTL and testbench



---
 rtl/alu_exec_ctrl.sv | 152 +++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// Issue/execute sequencer for an external 8-bit ALU: accepts one instruction at a time,
// drives registered operands through IDLE->DEC->EXE->RET, and writes back result and flags.
module alu_exec_ctrl #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [W+7:0]   instr,
  output logic [3:0]     alu_opcode,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_result,
  input  logic [2:0]     alu_flag,
  output logic [2:0]     flag_q,
  output logic           retire,
  input  logic [1:0]     dbg_sel,
  output logic [W-1:0]   dbg_data
);

  localparam int NREG = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEC  = 2'd1,
    EXE  = 2'd2,
    RET  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           instr_ready_q, instr_ready_d;
  logic           retire_q, retire_d;
  logic [W+7:0]   instr_lat_q, instr_lat_d;
  logic [3:0]     alu_opcode_q, alu_opcode_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [2:0]     flag_d;
  logic [W-1:0]   regs_q [NREG];
  logic [W-1:0]   regs_d [NREG];

  logic           accept;
  logic [3:0]     op;
  logic [1:0]     rd;
  logic [1:0]     rs;
  logic [W-1:0]   imm;
  logic           is_cmp;

  assign accept = instr_valid & instr_ready_q;
  assign op     = instr_lat_q[W+7:W+4];
  assign rd     = instr_lat_q[W+3:W+2];
  assign rs     = instr_lat_q[W+1:W];
  assign imm    = instr_lat_q[W-1:0];
  assign is_cmp = (op == 4'b0111) || (op == 4'b1111);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d       = state_q;
    instr_ready_d = instr_ready_q;
    retire_d      = 1'b0;
    instr_lat_d   = instr_lat_q;
    alu_opcode_d  = alu_opcode_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    flag_d        = flag_q;
    regs_d        = regs_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d       = DEC;
          instr_lat_d   = instr;
          instr_ready_d = 1'b0;
        end else if (!instr_ready_q) begin
          // Only reachable on the first edge after reset release.
          instr_ready_d = 1'b1;
        end
      end
      DEC: begin
        state_d      = EXE;
        alu_opcode_d = op;
        // Operands are read here, before the EXE write, so rd==rs sees the old value.
        case (op)
          4'b0000, 4'b0010: begin
            alu_a_d = regs_q[rs];
            alu_b_d = '0;
          end
          4'b0001, 4'b0011: begin
            alu_a_d = imm;
            alu_b_d = '0;
          end
          4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1010: begin
            alu_a_d = regs_q[rd];
            alu_b_d = regs_q[rs];
          end
          default: begin
            alu_a_d = regs_q[rd];
            alu_b_d = imm;
          end
        endcase
      end
      EXE: begin
        state_d  = RET;
        retire_d = 1'b1;
        flag_d   = alu_flag;
        if (!is_cmp) begin
          regs_d[rd] = alu_result;
        end
      end
      RET: begin
        state_d       = IDLE;
        instr_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      instr_ready_q <= 1'b0;
      retire_q      <= 1'b0;
      instr_lat_q   <= '0;
      alu_opcode_q  <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      flag_q        <= '0;
      // NOTE: the register file is architectural state that must read zero after reset,
      // so it is reset like any other flop rather than left as an unreset RAM.
      regs_q        <= '{default: '0};
    end else begin
      state_q       <= state_d;
      instr_ready_q <= instr_ready_d;
      retire_q      <= retire_d;
      instr_lat_q   <= instr_lat_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      flag_q        <= flag_d;
      regs_q        <= regs_d;
    end
  end

  assign instr_ready = instr_ready_q;
  assign retire      = retire_q;
  assign alu_opcode  = alu_opcode_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign dbg_data    = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural ALU stub closing the loop:
// add carries out of bit 7; subtract/compare return |A-B| with N and C marking a borrow.
module tb_alu_exec_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_valid;
  logic         instr_ready;
  logic [15:0]  instr;
  logic [3:0]   alu_opcode;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic [7:0]   alu_result;
  logic [2:0]   alu_flag;
  logic [2:0]   flag_q;
  logic         retire;
  logic [1:0]   dbg_sel;
  logic [7:0]   dbg_data;

  int checks   = 0;
  int failures = 0;

  alu_exec_ctrl #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_flag    (alu_flag),
    .flag_q      (flag_q),
    .retire      (retire),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  logic [8:0] sum;
  logic [7:0] res;
  logic       n_f, z_f, c_f, sub_op;

  always_comb begin
    sum    = '0;
    res    = '0;
    c_f    = 1'b0;
    sub_op = 1'b0;
    case (alu_opcode)
      4'b0100, 4'b1100: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        res = sum[7:0];
        c_f = sum[8];
      end
      4'b0101, 4'b1101, 4'b0111, 4'b1111: begin
        sub_op = 1'b1;
        c_f    = (alu_a < alu_b);
        res    = c_f ? (alu_b - alu_a) : (alu_a - alu_b);
      end
      4'b0110, 4'b1110: res = alu_a & alu_b;
      4'b1000, 4'b1001: res = alu_a | alu_b;
      4'b1010, 4'b1011: res = alu_a ^ alu_b;
      default:          res = alu_a;
    endcase
    z_f        = (res == 8'h00);
    n_f        = sub_op ? c_f : res[7];
    alu_result = res;
    alu_flag   = {c_f, z_f, n_f};
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input logic [1:0] sel, input logic [7:0] exp, input string tag);
    dbg_sel = sel;
    #1;
    check(tag, 16'(dbg_data), 16'(exp));
  endtask

  // Issues one word, then verifies the retire pulse lands 3 cycles after accept and lasts one cycle.
  task automatic run_instr(input logic [15:0] word, input string tag);
    int wait_cnt;
    int lat;
    @(negedge clk);
    wait_cnt = 0;
    while (!instr_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check({tag, " ready"}, 16'(instr_ready), 16'd1);
    instr_valid = 1'b1;
    instr       = word;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'h0000;
    lat = 1;
    while (!retire && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " retire latency"}, 16'(lat), 16'd3);
    @(negedge clk);
    check({tag, " retire width"}, 16'(retire), 16'd0);
  endtask

  logic [15:0] burst [12] = '{
    16'h10A0, 16'h1CE1, 16'h1CE2, 16'h1CE3,
    16'h14A1, 16'h1CE5, 16'h1CE6, 16'h1CE7,
    16'h18A2, 16'h1CE9, 16'h1CEA, 16'h1CEB
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int ret;

    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    dbg_sel     = 2'd0;

    #12;
    check("rst ready", 16'(instr_ready), 16'd0);
    check("rst retire", 16'(retire), 16'd0);
    check("rst flag", 16'(flag_q), 16'd0);
    check("rst opcode", 16'(alu_opcode), 16'd0);
    check("rst alu_a", 16'(alu_a), 16'd0);
    check("rst alu_b", 16'(alu_b), 16'd0);
    for (int i = 0; i < 4; i++) check_reg(2'(i), 8'h00, "rst reg");
    @(negedge clk);
    check("ready held in rst", 16'(instr_ready), 16'd0);
    #3 rst = 1'b0;
    #1;
    check("ready before first edge", 16'(instr_ready), 16'd0);
    @(negedge clk);
    check("ready after release", 16'(instr_ready), 16'd1);

    run_instr(16'h14C8, "ldi r1");
    check_reg(2'd1, 8'hC8, "ldi r1 value");
    check("ldi r1 flag", 16'(flag_q), 16'b001);

    run_instr(16'hC450, "addi r1");
    check_reg(2'd1, 8'h18, "addi r1 value");
    check("addi r1 flag", 16'(flag_q), 16'b100);
    check("addi opcode hold", 16'(alu_opcode), 16'hC);
    check("addi alu_a hold", 16'(alu_a), 16'hC8);
    check("addi alu_b hold", 16'(alu_b), 16'h50);

    run_instr(16'h1805, "ldi r2");
    check_reg(2'd2, 8'h05, "ldi r2 value");
    run_instr(16'hD807, "subi r2 7");
    check_reg(2'd2, 8'h02, "subi r2 7 value");
    check("subi r2 7 flag", 16'(flag_q), 16'b101);
    run_instr(16'hD801, "subi r2 1");
    check_reg(2'd2, 8'h01, "subi r2 1 value");
    check("subi r2 1 flag", 16'(flag_q), 16'b000);

    run_instr(16'hF418, "cmpi eq");
    check("cmpi eq flag", 16'(flag_q), 16'b010);
    check_reg(2'd1, 8'h18, "cmpi eq r1");
    run_instr(16'hF420, "cmpi lt");
    check("cmpi lt flag", 16'(flag_q), 16'b101);
    check_reg(2'd1, 8'h18, "cmpi lt r1");
    check_reg(2'd2, 8'h01, "cmpi lt r2");

    // Valid held high with a new word every cycle: only words 0, 4 and 8 land on accept edges.
    acc = 0;
    ret = 0;
    for (int k = 0; k < 16; k++) begin
      if (k < 12) begin
        instr_valid = 1'b1;
        instr       = burst[k];
      end else begin
        instr_valid = 1'b0;
        instr       = 16'h0000;
      end
      if (instr_valid && instr_ready) acc++;
      @(negedge clk);
      if (retire) ret++;
    end
    check("burst accepts", 16'(acc), 16'd3);
    check("burst retires", 16'(ret), 16'd3);
    check_reg(2'd0, 8'hA0, "burst r0");
    check_reg(2'd1, 8'hA1, "burst r1");
    check_reg(2'd2, 8'hA2, "burst r2");
    check_reg(2'd3, 8'h00, "burst r3");

    run_instr(16'h1C11, "ldi r3");
    check_reg(2'd3, 8'h11, "ldi r3 value");
    instr_valid = 1'b1;
    instr       = 16'h4F00;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'h0000;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort retire", 16'(retire), 16'd0);
    check("abort flag", 16'(flag_q), 16'd0);
    check("abort ready", 16'(instr_ready), 16'd0);
    check("abort alu_a", 16'(alu_a), 16'd0);
    check_reg(2'd3, 8'h00, "abort r3");
    @(negedge clk);
    check("abort retire later", 16'(retire), 16'd0);
    #3 rst = 1'b0;
    @(negedge clk);
    check("abort ready release", 16'(instr_ready), 16'd1);
    check("abort no retire", 16'(retire), 16'd0);
    check_reg(2'd3, 8'h00, "abort r3 after");

    run_instr(16'hCC80, "addi r3 post");
    check_reg(2'd3, 8'h80, "addi r3 post value");
    check("addi r3 post flag", 16'(flag_q), 16'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
